// File: rtl/conv_sequencer.sv
// Job controller for the 3x3 convolution filter: holds the weight banks, presents the
// selected kernel, streams one image from single-port memory and reports done/timeout.
module conv_sequencer #(
    parameter int  IMG_W     = 28,
    parameter int  IMG_H     = 28,
    parameter int  ADDR_W    = 10,
    parameter int  N_KERNELS = 4,
    parameter int  TIMEOUT   = 1024,
    localparam int SEL_W     = $clog2(N_KERNELS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [SEL_W-1:0]   kernel_sel_i,
    input  logic [ADDR_W-1:0]  base_addr_i,
    input  logic               wgt_we_i,
    input  logic [SEL_W-1:0]   wgt_bank_i,
    input  logic [3:0]         wgt_tap_i,
    input  logic [15:0]        wgt_data_i,
    output logic [143:0]       k_val_o,
    output logic               mem_re_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic [7:0]         mem_data_i,
    input  logic               pause_i,
    output logic [7:0]         pixel_o,
    output logic               pix_valid_o,
    input  logic               kernel_constructed_i,
    input  logic               conv_finished_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int NTAPS = 9;

    typedef enum logic [2:0] {
        IDLE, LOAD_K, STREAM, DRAIN, WAIT_FIN, DONE
    } state_e;

    state_e                              state_q;
    logic [SEL_W-1:0]                    sel_q;
    logic [ADDR_W-1:0]                   base_q;
    logic [CNT_W-1:0]                    cnt_q;
    logic [TMO_W-1:0]                    tmo_q;
    logic                                busy_q;
    logic                                done_q;
    logic [1:0]                          vld_pipe_q;
    logic [7:0]                          pixel_q;
    logic [N_KERNELS-1:0][16*NTAPS-1:0]  bank_q;

    logic             rd_en;
    logic             last_rd;
    logic             tmo_hit;
    logic             wgt_ok;
    logic [TMO_W-1:0] tmo_inc;

    assign rd_en   = (state_q == STREAM) && !pause_i;
    assign last_rd = rd_en && (cnt_q == CNT_W'(NPIX - 1));
    assign tmo_inc = (tmo_q == TMO_W'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1;

    // Timeout fires in the last waiting cycle, so err_o lands while busy_o is still high.
    assign tmo_hit = (tmo_q >= TMO_W'(TIMEOUT - 1)) &&
                     (((state_q == LOAD_K)   && !kernel_constructed_i) ||
                      ((state_q == WAIT_FIN) && !conv_finished_i));

    // The active bank is frozen for the whole job; writes to any other bank still land.
    assign wgt_ok = wgt_we_i && (wgt_tap_i < 4'd9) && !(busy_q && (wgt_bank_i == sel_q));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_q <= '0;
        end else if (wgt_ok) begin
            bank_q[wgt_bank_i][16*wgt_tap_i +: 16] <= wgt_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sel_q   <= kernel_sel_i;
                        base_q  <= base_addr_i;
                        cnt_q   <= '0;
                        tmo_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD_K;
                    end
                end
                LOAD_K: begin
                    if (kernel_constructed_i) begin
                        state_q <= STREAM;
                    end else if (tmo_hit) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_inc;
                    end
                end
                STREAM: begin
                    if (rd_en) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_rd) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Once no read is in flight, the final pixel is on the output this cycle.
                    if (!vld_pipe_q[0]) begin
                        tmo_q   <= '0;
                        state_q <= WAIT_FIN;
                    end
                end
                WAIT_FIN: begin
                    if (conv_finished_i) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (tmo_hit) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_inc;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // vld_pipe_q[0]: read data arrives this cycle; vld_pipe_q[1]: pixel presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe_q <= '0;
            pixel_q    <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], rd_en};
            if (vld_pipe_q[0]) pixel_q <= mem_data_i;
        end
    end

    assign k_val_o     = bank_q[sel_q];
    assign mem_re_o    = rd_en;
    assign mem_addr_o  = base_q + ADDR_W'(cnt_q);
    assign pixel_o     = pixel_q;
    assign pix_valid_o = vld_pipe_q[1];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = tmo_hit;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: 4x4 image, TIMEOUT=16, directed jobs checked against a
// transaction-level model of weights, read addresses and pixel order.
module tb_conv_sequencer;
    localparam int W = 4, H = 4, AW = 10, NK = 4, TMO = 16, N = W * H;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           start_i = 1'b0;
    logic [1:0]     kernel_sel_i = '0;
    logic [AW-1:0]  base_addr_i = '0;
    logic           wgt_we_i = 1'b0;
    logic [1:0]     wgt_bank_i = '0;
    logic [3:0]     wgt_tap_i = '0;
    logic [15:0]    wgt_data_i = '0;
    logic [143:0]   k_val_o;
    logic           mem_re_o;
    logic [AW-1:0]  mem_addr_o;
    logic [7:0]     mem_data_i;
    logic           pause_i = 1'b0;
    logic [7:0]     pixel_o;
    logic           pix_valid_o;
    logic           kernel_constructed_i = 1'b0;
    logic           conv_finished_i = 1'b0;
    logic           busy_o, done_o, err_o;

    conv_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .N_KERNELS(NK), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .kernel_sel_i(kernel_sel_i),
        .base_addr_i(base_addr_i), .wgt_we_i(wgt_we_i), .wgt_bank_i(wgt_bank_i),
        .wgt_tap_i(wgt_tap_i), .wgt_data_i(wgt_data_i), .k_val_o(k_val_o),
        .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .pause_i(pause_i), .pixel_o(pixel_o), .pix_valid_o(pix_valid_o),
        .kernel_constructed_i(kernel_constructed_i), .conv_finished_i(conv_finished_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

    initial forever #5 clk_i = ~clk_i;

    // image memory: mem[a] = a[7:0], one-cycle read latency
    always @(posedge clk_i) mem_data_i <= mem_re_o ? mem_addr_o[7:0] : 8'hEE;

    int checks = 0, errors = 0, cyc = 0;
    int exp_sel = 0, exp_base = 0, job_active = 0, c0 = 0;
    int rd_k = 0, px_k = 0, done_n = 0, err_n = 0, done_cyc = 0, err_cyc = 0;
    int first_pix = 0, last_pix = 0;
    logic [7:0]    first_val;
    logic [AW-1:0] last_rd_addr;
    logic [15:0]   model_w [NK][9];

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic chk(input string nm, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [143:0] build_k(input int b);
        logic [143:0] v;
        v = '0;
        for (int t = 0; t < 9; t++) v[16*t +: 16] = model_w[b][t];
        return v;
    endfunction

    // weight model: writes land unless they hit the active bank of a running job
    initial begin
        for (int b = 0; b < NK; b++) for (int t = 0; t < 9; t++) model_w[b][t] = '0;
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                for (int b = 0; b < NK; b++) for (int t = 0; t < 9; t++) model_w[b][t] = '0;
            end else if (wgt_we_i && wgt_tap_i < 4'd9 &&
                         !(job_active != 0 && int'(wgt_bank_i) == exp_sel)) begin
                model_w[wgt_bank_i][wgt_tap_i] = wgt_data_i;
            end
        end
    end

    // compare process: every cycle out of reset
    initial forever begin
        @(negedge clk_i);
        if (rst_ni) begin
            chk("busy", busy_o, job_active);
            chk("done_err_excl", done_o & err_o, 0);
            if (done_o) begin done_n++; done_cyc = cyc; end
            if (err_o) begin err_n++; err_cyc = cyc; end
            if (mem_re_o) begin
                chk("rd_addr", mem_addr_o, (exp_base + rd_k) % 1024);
                chk("rd_legal", {job_active == 1, rd_k < N, pause_i == 1'b0}, 3'b111);
                last_rd_addr = mem_addr_o;
                rd_k++;
            end
            if (pix_valid_o) begin
                chk("pixel", pixel_o, (exp_base + px_k) % 256);
                chk("px_extra", px_k < N, 1);
                if (px_k == 0) begin first_pix = cyc; first_val = pixel_o; end
                last_pix = cyc;
                px_k++;
            end
            if (busy_o) chk("k_val", k_val_o, build_k(exp_sel));
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_kval"}, k_val_o, '0);
        chk({tag, "_re"}, mem_re_o, 0);
        chk({tag, "_addr"}, mem_addr_o, 0);
        chk({tag, "_pix"}, pixel_o, 0);
        chk({tag, "_pixv"}, pix_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic wr(input int b, input int t, input int d);
        wgt_we_i = 1'b1; wgt_bank_i = 2'(b); wgt_tap_i = 4'(t); wgt_data_i = 16'(d);
        tick(1);
        wgt_we_i = 1'b0;
    endtask

    // One job; caller stands just after a rising edge. kc_dly/cf_dly < 0 withhold the handshake.
    task automatic run_job(input int sel, input int base, input int kc_dly, input int cf_dly,
                           input int pause_at, input int pause_len, input bit mid_ops,
                           input int abort_at);
        int off, p_left;
        bit p_started;
        p_left = 0; p_started = 0;
        exp_sel = sel; exp_base = base;
        rd_k = 0; px_k = 0; done_n = 0; err_n = 0; first_pix = -1; last_pix = -1;
        start_i = 1'b1; kernel_sel_i = 2'(sel); base_addr_i = AW'(base); c0 = cyc;
        tick(1);
        start_i = 1'b0; wgt_we_i = 1'b0; job_active = 1;
        for (int i = 0; i < 400; i++) begin
            if (done_n + err_n > 0) break;
            off = cyc - c0;
            if (abort_at >= 0 && off == abort_at) begin
                rst_ni = 1'b0; job_active = 0;
                #1;
                chk_reset_outs("mid_rst");
                tick(1);
                rst_ni = 1'b1;
                kernel_constructed_i = 1'b0; conv_finished_i = 1'b0; pause_i = 1'b0;
                return;
            end
            start_i = 1'b0; wgt_we_i = 1'b0;
            kernel_constructed_i = (kc_dly >= 0 && off >= 1 + kc_dly);
            conv_finished_i = (cf_dly >= 0 && px_k == N && cyc >= last_pix + cf_dly);
            if (pause_at >= 0 && !p_started && rd_k == pause_at) begin
                p_started = 1; p_left = pause_len;
            end
            pause_i = (p_left > 0);
            if (p_left > 0) p_left--;
            if (mid_ops) begin
                case (off)
                    8:  begin wgt_we_i = 1'b1; wgt_bank_i = 2'(sel); wgt_tap_i = 4'd0; wgt_data_i = 16'h7777; end
                    9:  begin wgt_we_i = 1'b1; wgt_bank_i = 2'd3; wgt_tap_i = 4'd4; wgt_data_i = 16'h1234; end
                    10: begin start_i = 1'b1; kernel_sel_i = 2'd3; base_addr_i = 10'h200; end
                    default: ;
                endcase
            end
            tick(1);
        end
        chk("job_end", done_n + err_n, 1);
        job_active = 0;
        start_i = 1'b0; wgt_we_i = 1'b0; pause_i = 1'b0;
        kernel_constructed_i = 1'b0; conv_finished_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset with inputs toggling
        #1;
        chk_reset_outs("rst0");
        repeat (5) begin
            tick(1);
            start_i = 1'($urandom); kernel_sel_i = 2'($urandom); base_addr_i = AW'($urandom);
            wgt_we_i = 1'($urandom); wgt_bank_i = 2'($urandom); wgt_tap_i = 4'($urandom);
            wgt_data_i = 16'($urandom); pause_i = 1'($urandom);
            kernel_constructed_i = 1'($urandom); conv_finished_i = 1'($urandom);
        end
        #2;
        chk_reset_outs("rst_tog");
        start_i = 0; wgt_we_i = 0; pause_i = 0; kernel_constructed_i = 0; conv_finished_i = 0;
        tick(1);
        rst_ni = 1'b1;
        tick(2);

        // bank 1 = 1..9, plus an out-of-range tap that must be ignored
        for (int t = 0; t < 9; t++) wr(1, t, t + 1);
        wr(1, 12, 16'hFFFF);
        tick(1);

        // basic job
        run_job(1, 10'h010, 3, 2, -1, 0, 0, -1);
        chk("A_done", done_n, 1);
        chk("A_err", err_n, 0);
        chk("A_reads", rd_k, 16);
        chk("A_pixels", px_k, 16);
        chk("A_span", last_pix - first_pix, 15);
        chk("A_first_pix", first_val, 8'h10);
        chk("A_last_addr", last_rd_addr, 10'h01F);
        chk("A_kval_lit", k_val_o, 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001);
        tick(2);

        // immediate handshakes: start to done is N+5
        run_job(1, 10'h080, 0, 0, -1, 0, 0, -1);
        chk("B_latency", done_cyc - c0, 21);
        chk("B_pixels", px_k, 16);
        tick(2);

        // pause for 5 cycles after the 6th read
        run_job(1, 10'h010, 3, 2, 6, 5, 0, -1);
        chk("P_done", done_n, 1);
        chk("P_pixels", px_k, 16);
        chk("P_span", last_pix - first_pix, 20);
        tick(2);

        // address wrap
        run_job(0, 10'h3FC, 0, 1, -1, 0, 0, -1);
        chk("W_done", done_n, 1);
        chk("W_first_pix", first_val, 8'hFC);
        chk("W_last_addr", last_rd_addr, 10'h00B);
        tick(2);

        // kernel never constructed
        run_job(2, 10'h050, -1, 0, -1, 0, 0, -1);
        chk("TK_err", err_n, 1);
        chk("TK_done", done_n, 0);
        chk("TK_cycle", err_cyc - c0, 16);
        chk("TK_reads", rd_k, 0);
        tick(2);

        // filter never finishes
        run_job(1, 10'h040, 0, -1, -1, 0, 0, -1);
        chk("TF_err", err_n, 1);
        chk("TF_done", done_n, 0);
        chk("TF_pixels", px_k, 16);
        chk("TF_cycle", err_cyc - last_pix, 16);
        tick(2);

        // mid-job start ignored, active-bank write dropped, other-bank write lands
        run_job(1, 10'h100, 0, 1, -1, 0, 1, -1);
        chk("M_done", done_n, 1);
        chk("M_reads", rd_k, 16);
        chk("M_kval_lit", k_val_o, 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001);
        tick(2);

        // write in the start cycle to the selected bank is accepted
        wgt_we_i = 1'b1; wgt_bank_i = 2'd3; wgt_tap_i = 4'd0; wgt_data_i = 16'h00AB;
        run_job(3, 10'h000, -1, 0, -1, 0, 0, -1);
        chk("S_err", err_n, 1);
        chk("S_kval_lit", k_val_o, 144'h1234_0000_0000_0000_00AB);
        tick(2);

        // reset mid-STREAM, then a clean job
        run_job(1, 10'h000, 0, 0, -1, 0, 0, 6);
        tick(2);
        run_job(1, 10'h020, 0, 0, -1, 0, 0, -1);
        chk("R_done", done_n, 1);
        chk("R_latency", done_cyc - c0, 21);
        chk("R_pixels", px_k, 16);
        chk("R_kval", k_val_o, '0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
